// File: rtl/fetch_halfword_unit_if.sv
// Instruction-memory bus and fetch/decode output bundle of fetch_halfword_unit.
// master = fetch stage, slave = memory/decode side.
interface fetch_halfword_unit_if;
  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic [15:0] imem_data_i;
  logic [15:0] instruction_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
  logic        second_half_o;

  modport master (
    output imem_addr_o, imem_req_o, instruction_o, pc_o, instr_valid_o, second_half_o,
    input  imem_data_i
  );

  modport slave (
    input  imem_addr_o, imem_req_o, instruction_o, pc_o, instr_valid_o, second_half_o,
    output imem_data_i
  );
endinterface

// File: rtl/fetch_halfword_unit.sv
// Thumb halfword fetch stage: fetch PC, 1-cycle imem, fetch/decode register and 32-bit pair tagging.
// `define FETCH_SKID_EN adds a one-entry skid buffer; without it a stalled response is refetched.
module fetch_halfword_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  branch_valid_i,
  input  logic [31:0]           branch_target_i,
  fetch_halfword_unit_if.master bus
);

  typedef enum logic {ST_FIRST = 1'b0, ST_SECOND = 1'b1} pair_state_e;

  pair_state_e state_q, state_d;
  logic        tag_en;
  logic        tag_second;
  logic        is_prefix;
  logic        issue;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        second_q, second_d;

`ifdef FETCH_SKID_EN
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_data_q, skid_data_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_second_q, skid_second_d;
`endif

  assign issue     = !rst_i && !stall_i && !branch_valid_i;
  assign is_prefix = bus.imem_data_i[15:11] inside {5'b11101, 5'b11110, 5'b11111};

`ifdef FETCH_SKID_EN
  // Every response lands in either the output or the skid, so every one is tagged.
  assign tag_en = resp_valid_q && !branch_valid_i;
`else
  assign tag_en = resp_valid_q && !branch_valid_i && !stall_i;
`endif

  // Pairing FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i || branch_valid_i) begin
      state_q <= ST_FIRST;
    end else begin
      state_q <= state_d;
    end
  end

  // Pairing FSM: next state
  always_comb begin
    state_d = state_q;
    if (tag_en) begin
      case (state_q)
        ST_FIRST:  if (is_prefix) state_d = ST_SECOND;
        ST_SECOND: state_d = ST_FIRST;
      endcase
    end
  end

  // Pairing FSM: output
  always_comb begin
    tag_second = (state_q == ST_SECOND);
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    resp_valid_d = issue;
    resp_pc_d    = resp_pc_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    second_d     = second_q;
`ifdef FETCH_SKID_EN
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    skid_second_d = skid_second_q;
`endif

    if (issue) begin
      resp_pc_d  = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd2;
    end

    if (branch_valid_i) begin
      fetch_pc_d = {branch_target_i[31:1], 1'b0};
      valid_d    = 1'b0;
`ifdef FETCH_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (!stall_i) begin
`ifdef FETCH_SKID_EN
      if (skid_valid_q) begin
        // Older skid entry goes out first; a concurrent response takes its place.
        instr_d       = skid_data_q;
        pc_d          = skid_pc_q;
        valid_d       = 1'b1;
        second_d      = skid_second_q;
        skid_valid_d  = resp_valid_q;
        skid_data_d   = bus.imem_data_i;
        skid_pc_d     = resp_pc_q;
        skid_second_d = tag_second;
      end else
`endif
      if (resp_valid_q) begin
        instr_d  = bus.imem_data_i;
        pc_d     = resp_pc_q;
        valid_d  = 1'b1;
        second_d = tag_second;
      end else begin
        valid_d = 1'b0;
      end
    end else if (resp_valid_q) begin
`ifdef FETCH_SKID_EN
      skid_valid_d  = 1'b1;
      skid_data_d   = bus.imem_data_i;
      skid_pc_d     = resp_pc_q;
      skid_second_d = tag_second;
`else
      // Response is dropped; rewind so it is fetched again after the stall.
      fetch_pc_d = resp_pc_q;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q   <= {RESET_PC[31:1], 1'b0};
      resp_valid_q <= 1'b0;
      resp_pc_q    <= 32'd0;
      instr_q      <= 16'd0;
      pc_q         <= 32'd0;
      valid_q      <= 1'b0;
      second_q     <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_valid_q  <= 1'b0;
      skid_data_q   <= 16'd0;
      skid_pc_q     <= 32'd0;
      skid_second_q <= 1'b0;
`endif
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      second_q     <= second_d;
`ifdef FETCH_SKID_EN
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_pc_q     <= skid_pc_d;
      skid_second_q <= skid_second_d;
`endif
    end
  end

  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.imem_req_o    = issue;
  assign bus.instruction_o = instr_q;
  assign bus.pc_o          = pc_q;
  assign bus.instr_valid_o = valid_q;
  assign bus.second_half_o = second_q;

endmodule

// File: tb/tb_fetch_halfword_unit.sv
// Directed self-checking bench for fetch_halfword_unit (RESET_PC = 0x100, 1-cycle memory model).
module tb_fetch_halfword_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [49:0] obs;
  logic [49:0] exp;
  logic [32:0] bus_obs;
  logic [32:0] bus_exp;

`ifdef FETCH_SKID_EN
  localparam int EXP_BUBBLES = 0;
`else
  localparam int EXP_BUBBLES = 1;
`endif

  fetch_halfword_unit_if bus ();

  fetch_halfword_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .branch_valid_i (branch_valid),
    .branch_target_i(branch_target),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Memory image: BL pair at 0x200, otherwise 16-bit ops {4'h2, addr[12:1]}.
  function automatic logic [15:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0200: return 16'hF000;
      32'h0000_0202: return 16'hF800;
      32'h0000_0204: return 16'h2001;
      default:       return {4'h2, a[12:1]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req_o) bus.imem_data_i <= mem_word(bus.imem_addr_o);
  end

  assign obs     = {bus.instr_valid_o, bus.pc_o, bus.instruction_o, bus.second_half_o};
  assign bus_obs = {bus.imem_req_o, bus.imem_addr_o};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_branch(input logic [31:0] target);
    branch_valid  = 1'b1;
    branch_target = target;
    step();
    branch_valid  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = 32'd0;
    repeat (3) step();
    exp = '0;
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected %h", obs, exp);
    end else $display("[TB] reset_outputs ok");
    bus_exp = {1'b0, 32'h0000_0100};
    tests_run++;
    if (bus_obs !== bus_exp) begin
      tests_failed++; $display("FAIL reset_imem: got %h expected %h", bus_obs, bus_exp);
    end else $display("[TB] reset_imem ok");
    rst = 1'b0;
    #1;
    bus_exp = {1'b1, 32'h0000_0100};
    tests_run++;
    if (bus_obs !== bus_exp) begin
      tests_failed++; $display("FAIL first_request: got %h expected %h", bus_obs, bus_exp);
    end else $display("[TB] first_request ok addr=%h", bus.imem_addr_o);
    step();
    tests_run++;
    if (bus.instr_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_latency: got valid %b expected 0", bus.instr_valid_o);
    end else $display("[TB] reset_latency ok");
    for (int i = 0; i < 5; i++) begin
      step();
      exp = {1'b1, 32'h0000_0100 + 32'(2 * i), 16'h2080 + 16'(i), 1'b0};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL seq_%0d: got %h expected %h", i, obs, exp);
      end else $display("[TB] seq pc=%h instr=%h", bus.pc_o, bus.instruction_o);
    end
  endtask

  task automatic test_stall();
    int bubbles;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = {1'b1, 32'h0000_0108, 16'h2084, 1'b0};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL stall_hold_%0d: got %h expected %h", i, obs, exp);
      end else $display("[TB] stall hold pc=%h", bus.pc_o);
    end
    stall = 1'b0;
    bubbles = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.instr_valid_o) break;
      bubbles++;
    end
    tests_run++;
    if (bubbles !== EXP_BUBBLES) begin
      tests_failed++; $display("FAIL stall_bubbles: got %0d expected %0d", bubbles, EXP_BUBBLES);
    end else $display("[TB] stall bubbles=%0d", bubbles);
    exp = {1'b1, 32'h0000_010A, 16'h2085, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL stall_next: got %h expected %h", obs, exp);
    end else $display("[TB] post-stall pc=%h", bus.pc_o);
    step();
    exp = {1'b1, 32'h0000_010C, 16'h2086, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL stall_next2: got %h expected %h", obs, exp);
    end else $display("[TB] post-stall pc=%h", bus.pc_o);
  endtask

  task automatic test_pair();
    logic [49:0] pair_exp [3];
    pair_exp[0] = {1'b1, 32'h0000_0200, 16'hF000, 1'b0};
    pair_exp[1] = {1'b1, 32'h0000_0202, 16'hF800, 1'b1};
    pair_exp[2] = {1'b1, 32'h0000_0204, 16'h2001, 1'b0};
    do_branch(32'h0000_0200);
    bus_exp = {1'b1, 32'h0000_0200};
    tests_run++;
    if (bus_obs !== bus_exp || bus.instr_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL branch_b1: got %h/%b expected %h/0", bus_obs, bus.instr_valid_o, bus_exp);
    end else $display("[TB] branch B+1 addr=%h", bus.imem_addr_o);
    step();
    tests_run++;
    if (bus.instr_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL branch_b2: got valid %b expected 0", bus.instr_valid_o);
    end else $display("[TB] branch B+2 bubble");
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (obs !== pair_exp[i]) begin
        tests_failed++; $display("FAIL pair_%0d: got %h expected %h", i, obs, pair_exp[i]);
      end else $display("[TB] pair pc=%h instr=%h second=%b", bus.pc_o, bus.instruction_o, bus.second_half_o);
    end
  endtask

  task automatic test_redirect_in_second();
    do_branch(32'h0000_0200);
    step();
    step();
    stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h0000_0301;
    #1;
    tests_run++;
    if (bus.imem_req_o !== 1'b0) begin
      tests_failed++; $display("FAIL redirect_req: got %b expected 0", bus.imem_req_o);
    end else $display("[TB] redirect cycle no request");
    step();
    stall = 1'b0; branch_valid = 1'b0;
    #1;
    bus_exp = {1'b1, 32'h0000_0300};
    tests_run++;
    if (bus_obs !== bus_exp || bus.instr_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL redirect_b1: got %h/%b expected %h/0", bus_obs, bus.instr_valid_o, bus_exp);
    end else $display("[TB] redirect B+1 addr=%h", bus.imem_addr_o);
    step();
    tests_run++;
    if (bus.instr_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL redirect_b2: got valid %b expected 0", bus.instr_valid_o);
    end else $display("[TB] redirect B+2 bubble");
    for (int i = 0; i < 2; i++) begin
      step();
      exp = {1'b1, 32'h0000_0300 + 32'(2 * i), 16'h2180 + 16'(i), 1'b0};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL redirect_out_%0d: got %h expected %h", i, obs, exp);
      end else $display("[TB] redirect pc=%h second=%b", bus.pc_o, bus.second_half_o);
    end
  endtask

  task automatic test_wrap();
    logic [49:0] wrap_exp [3];
    wrap_exp[0] = {1'b1, 32'hFFFF_FFFC, 16'h2FFE, 1'b0};
    wrap_exp[1] = {1'b1, 32'hFFFF_FFFE, 16'h2FFF, 1'b0};
    wrap_exp[2] = {1'b1, 32'h0000_0000, 16'h2000, 1'b0};
    do_branch(32'hFFFF_FFFC);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (obs !== wrap_exp[i]) begin
        tests_failed++; $display("FAIL wrap_%0d: got %h expected %h", i, obs, wrap_exp[i]);
      end else $display("[TB] wrap pc=%h", bus.pc_o);
    end
  endtask

  task automatic test_reset_midstall();
    stall = 1'b1;
    step();
    rst = 1'b1;
    step();
    exp = '0;
    bus_exp = {1'b0, 32'h0000_0100};
    tests_run++;
    if (obs !== exp || bus_obs !== bus_exp) begin
      tests_failed++; $display("FAIL midstall_reset: got %h/%h expected %h/%h", obs, bus_obs, exp, bus_exp);
    end else $display("[TB] mid-stall reset cleared");
    rst = 1'b0; stall = 1'b0;
    step();
    tests_run++;
    if (bus.instr_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL midstall_stale: got valid %b pc %h expected 0", bus.instr_valid_o, bus.pc_o);
    end else $display("[TB] no stale halfword after reset");
    step();
    exp = {1'b1, 32'h0000_0100, 16'h2080, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++; $display("FAIL midstall_restart: got %h expected %h", obs, exp);
    end else $display("[TB] restart pc=%h", bus.pc_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stall();
    test_pair();
    test_redirect_in_second();
    test_wrap();
    test_reset_midstall();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
